tsc_multi_trigger: RTL
======================

// Module: tsc_multi_trigger
// PURPOSE
//  Parametrised trigger sequence controller for the AES trojan-insertion benchmarks.
//  A free-running prescaler opens an "armed" window.
//  Inside that window, cycles where all N_COND rare-condition inputs are high are counted.
//  When the event counter MSB sets, the trigger output fires.
//  Generalises the fixed 8-bit, 2-input controller with: configurable widths and input count,
//  level/edge counting modes, a sticky fire state, and enable/clear controls.
// PARAMETERS
//  N_COND  2  number of condition inputs ANDed together (>=1)
//  PRE_W   8  prescaler width; armed = prescaler MSB (>=2)
//  EVT_W   8  event counter width; trigger threshold = 2^(EVT_W-1) (>=2)
//  MODE    0  0 = count every qualifying cycle, 1 = count rising edges of &cond only
//  STICKY  1  1 = latch FIRED until rst/clr, counters frozen; 0 = trigger follows evt_cnt MSB
// PORTS
//  clk      in   1       clock, all state updates on rising edge
//  rst      in   1       asynchronous reset, active-low
//  en       in   1       1 = prescaler/counters advance; 0 = all state held
//  clr      in   1       synchronous clear of all counters and FSM
//  cond     in   N_COND  rare-event condition inputs
//  armed    out  1       registered prescaler MSB
//  trigger  out  1       payload enable
//  evt_cnt  out  EVT_W   current event count
//  state    out  2       FSM state: 00 IDLE, 01 ARMED, 10 FIRED
// BEHAVIOUR
//  Reset (rst=0):
//   - Immediately (asynchronously) pre_cnt=0, evt_cnt=0, cond edge reg=0, state=IDLE.
//   - armed=0, trigger=0. Applies mid-operation, including in FIRED.
//  Priority per edge: rst > clr > en=0 (hold) > normal update.
//   - clr=1: same values as reset, taken at the clock edge, regardless of en.
//  Prescaler:
//   - pre_cnt <= pre_cnt+1 each enabled cycle; wraps modulo 2^PRE_W.
//   - armed = pre_cnt[PRE_W-1].
//  Qualify:
//   - all_c = &cond.
//   - MODE0: hit = en & armed & all_c.
//   - MODE1: hit = en & armed & all_c & ~all_c_q. all_c_q is registered all_c, updated only when en=1.
//   - hit uses current-cycle registered armed; it is not gated by the next prescaler value.
//  Event counter:
//   - evt_cnt <= evt_cnt+1 on hit. Result is visible one cycle after the hit cycle.
//   - STICKY=0: wraps modulo 2^EVT_W.
//  FSM (registered):
//   - IDLE->ARMED when next pre_cnt MSB=1.
//   - ARMED->IDLE when next pre_cnt MSB=0 (wrap).
//   - IDLE/ARMED->FIRED when STICKY=1 and next evt_cnt MSB=1.
//   - FIRED is left only via rst or clr. In FIRED, pre_cnt and evt_cnt freeze.
//   - STICKY=0: FIRED is never entered; state is IDLE/ARMED only.
//  trigger:
//   - STICKY=1: trigger = (state==FIRED).
//   - STICKY=0: trigger = evt_cnt[EVT_W-1], drops when evt_cnt wraps to 0.
//   - Rises in the same cycle evt_cnt first shows 2^(EVT_W-1). Zero added latency.
//  Simultaneous events:
//   - Hit on the edge where the prescaler wraps still counts.
//   - clr together with hit: clr wins, evt_cnt=0.
// TESTING (defaults unless noted)
//  1. Drive cond=11, en=1 from reset; hold rst low at cycle 300.
//     -> armed=1 after edge 128; evt_cnt=128, trigger=1, state=10 at edge 256.
//     -> All outputs 0 asynchronously on rst low.
//  2. Drive cond=10, en=1 for 1024 cycles.
//     -> evt_cnt=0, trigger=0; armed toggles every 128 cycles.
//  3. MODE=1, cond alternating 11/00 each cycle.
//     -> evt_cnt=64 after first armed window; trigger at end of second window (evt_cnt=128).
//  4. STICKY=0, cond=11 held.
//     -> trigger=1 while evt_cnt in 128..255; evt_cnt wraps 255->0, trigger drops to 0.
//  5. en=0 for 50 cycles mid-window.
//     -> pre_cnt, evt_cnt, state, all_c_q unchanged; counting resumes on en=1.
//  6. Pulse clr on the same edge as a hit while evt_cnt=127.
//     -> evt_cnt=0, state=IDLE, trigger=0, armed=0.

Source files
------------

// File: rtl/tsc_multi_trigger.sv
// Trigger sequence controller: a prescaler opens an armed window in which cycles with all
// condition inputs high are counted; the event counter MSB fires the trigger.
module tsc_multi_trigger #(
   parameter int unsigned N_COND = 2,
   parameter int unsigned PRE_W  = 8,
   parameter int unsigned EVT_W  = 8,
   parameter int unsigned MODE   = 0,
   parameter int unsigned STICKY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              clr,
   input  logic [N_COND-1:0] cond,
   output logic              armed,
   output logic              trigger,
   output logic [EVT_W-1:0]  evt_cnt,
   output logic [1:0]        state
);

   typedef enum logic [1:0] {
      StIdle  = 2'b00,
      StArmed = 2'b01,
      StFired = 2'b10
   } state_t;

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [EVT_W-1:0] evt_q, evt_d;
   logic             all_c_q, all_c_d;
   state_t           state_q, state_d;
   logic             all_c;
   logic             hit;

   assign all_c = &cond;
   // In edge mode a hit needs the previous enabled cycle's AND to have been low.
   assign hit   = en & armed & all_c & ((MODE == 0) | ~all_c_q);

   always_comb begin
      pre_d   = pre_q;
      evt_d   = evt_q;
      all_c_d = all_c_q;
      state_d = state_q;
      if (clr) begin
         pre_d   = '0;
         evt_d   = '0;
         all_c_d = 1'b0;
         state_d = StIdle;
      end else if (en) begin
         all_c_d = all_c;
         if (state_q != StFired) begin
            pre_d = pre_q + PRE_W'(1);
            evt_d = evt_q + EVT_W'(hit);
            if ((STICKY != 0) && evt_d[EVT_W-1]) begin
               state_d = StFired;
            end else if (pre_d[PRE_W-1]) begin
               state_d = StArmed;
            end else begin
               state_d = StIdle;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pre_q   <= '0;
         evt_q   <= '0;
         all_c_q <= 1'b0;
         state_q <= StIdle;
      end else begin
         pre_q   <= pre_d;
         evt_q   <= evt_d;
         all_c_q <= all_c_d;
         state_q <= state_d;
      end
   end

   assign armed   = pre_q[PRE_W-1];
   assign trigger = (STICKY != 0) ? (state_q == StFired) : evt_q[EVT_W-1];
   assign evt_cnt = evt_q;
   assign state   = state_q;

endmodule
